// File: rtl/boid_fix_pkg.sv
// boid_fix_pkg: shared signed fixed-point format and divider FSM states.
package boid_fix_pkg;
  localparam int FIX_WIDTH = 32;
  localparam int FIX_FRAC = 15;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} div_state_e;
endpackage

// File: rtl/fix_div_step.sv
// fix_div_step: one restoring-division step, shift in a dividend bit and conditionally subtract.
module fix_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] den_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] trial;
  always_comb begin
    trial = {rem_i, bit_i};
    q_o = trial >= {1'b0, den_i};
    rem_o = q_o ? WIDTH'(trial - {1'b0, den_i}) : trial[WIDTH-1:0];
  end
endmodule

// File: rtl/fix_seq_divider.sv
// fix_seq_divider: sequential signed fixed-point divider, one quotient bit per cycle,
// with divide-by-zero flag and saturation to the signed range.
module fix_seq_divider
  import boid_fix_pkg::*;
#(
  parameter int WIDTH = FIX_WIDTH,
  parameter int FRAC  = FIX_FRAC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic             div_zero,
  output logic             sat
);
  localparam int ITER = WIDTH + FRAC;
  localparam int CW = $clog2(ITER + 1);
  div_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, den_q, den_d, quot_q, quot_d, num_mag, den_mag, rem_nx;
  logic [ITER-1:0] quo_q, quo_d, quo_nx;
  logic neg_q, neg_d, dz_q, dz_d, sat_q, sat_d, q_bit, ovf;
  // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom
  fix_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q),
    .bit_i(quo_q[ITER-1]),
    .den_i(den_q),
    .rem_o(rem_nx),
    .q_o  (q_bit)
  );
  always_comb begin
    num_mag = num[WIDTH-1] ? -num : num;
    den_mag = den[WIDTH-1] ? -den : den;
    quo_nx = {quo_q[ITER-2:0], q_bit};
    ovf = neg_q ? ((quo_nx >> WIDTH) != '0 || (quo_nx[WIDTH-1] && quo_nx[WIDTH-2:0] != '0))
                : (quo_nx >> (WIDTH-1)) != '0;
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    den_d = den_q;
    quo_d = quo_q;
    neg_d = neg_q;
    quot_d = quot_q;
    dz_d = dz_q;
    sat_d = sat_q;
    if (state_q == IDLE && in_valid) begin
      state_d = den == '0 ? DONE : CALC;
      cnt_d = '0;
      rem_d = '0;
      den_d = den_mag;
      quo_d = {num_mag, {FRAC{1'b0}}};
      neg_d = num[WIDTH-1] ^ den[WIDTH-1];
      quot_d = '0;
      dz_d = den == '0;
      sat_d = 1'b0;
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + CW'(1);
      rem_d = rem_nx;
      quo_d = quo_nx;
      if (cnt_q == CW'(ITER - 1)) begin
        state_d = DONE;
        sat_d = ovf;
        quot_d = ovf ? {neg_q, {(WIDTH-1){~neg_q}}}
                     : (neg_q ? -quo_nx[WIDTH-1:0] : quo_nx[WIDTH-1:0]);
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      quo_q <= '0;
      neg_q <= 1'b0;
      quot_q <= '0;
      dz_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      den_q <= den_d;
      quo_q <= quo_d;
      neg_q <= neg_d;
      quot_q <= quot_d;
      dz_q <= dz_d;
      sat_q <= sat_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign quot = quot_q;
  assign div_zero = dz_q;
  assign sat = sat_q;
endmodule

// File: doc/fix_seq_divider.md
FIX_SEQ_DIVIDER -- requirements
Module: fix_seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal range 8..32).
REQ-002 SHALL have parameter FRAC, default 15, giving the number of fractional bits of the signed fixed-point format (FRAC < WIDTH-1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands valid.
REQ-006 SHALL have port in_ready  output  1  divider idle and able to accept operands.
REQ-007 SHALL have port num  input  WIDTH  signed fixed-point dividend.
REQ-008 SHALL have port den  input  WIDTH  signed fixed-point divisor.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port quot  output  WIDTH  signed fixed-point quotient num/den.
REQ-012 SHALL have port div_zero  output  1  result came from den == 0.
REQ-013 SHALL have port sat  output  1  result was clamped.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL accept operands on the rising edge where in_valid && in_ready, latch the operand magnitudes and the result sign (num[WIDTH-1] XOR den[WIDTH-1]), and go to CALC, or to DONE if den == 0.
REQ-016 SHALL compute, in CALC, the magnitude (|num| << FRAC) / |den| by restoring division producing one quotient bit per cycle, for ITER = WIDTH+FRAC cycles, using an iteration counter.
REQ-017 SHALL enter DONE on the ITER-th rising edge after the accepting edge (47 with defaults); den == 0 SHALL enter DONE on the first edge after acceptance.
REQ-018 SHALL truncate the magnitude toward zero, then negate it if the result sign is 1.
REQ-019 SHALL compute |x| of the most-negative input as the WIDTH-bit unsigned value 2^(WIDTH-1) without error.
REQ-020 SHALL saturate: a positive result whose magnitude exceeds 2^(WIDTH-1)-1 SHALL produce 2^(WIDTH-1)-1 with sat = 1.
REQ-021 SHALL saturate: a negative result whose magnitude exceeds 2^(WIDTH-1) SHALL produce -2^(WIDTH-1) with sat = 1.
REQ-022 SHALL, for den == 0, output quot = 0, div_zero = 1 and sat = 0, preserving the existing "no neighbours gives zero factor" behaviour.
REQ-023 SHALL hold quot, div_zero and sat stable while in DONE with out_ready = 0.
REQ-024 SHALL return to IDLE on the edge where out_valid && out_ready; operands are not accepted in that same cycle (throughput: one result per ITER+2 cycles minimum).
REQ-025 SHALL ignore num, den and in_valid while in CALC or DONE.
REQ-026 SHALL ignore out_ready outside DONE.

Reset
REQ-027 SHALL, on assertion of reset, immediately force state IDLE, clear the counter, and drive quot = 0, div_zero = 0, sat = 0, out_valid = 0 and in_ready = 1, regardless of clock.
REQ-028 SHALL discard any in-flight division on reset asserted mid-CALC or mid-DONE, producing no result after release.
REQ-029 SHALL accept new operands on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL take FIX_WIDTH = 32, FIX_FRAC = 15 and the FSM state enum typedef from shared package boid_fix_pkg.
REQ-031 SHALL place one restoring-division step (conditional subtract-and-shift, combinational) in sub-module fix_div_step, instantiated once.

Verification
REQ-032 SHALL cover: num=0x00008000 (1.0), den=0x00018000 (3.0) -> quot=0x00002AAA, sat=0, div_zero=0, out_valid 47 edges after accept.
REQ-033 SHALL cover: num=0xFFFC4000 (-7.5), den=0x00014000 (2.5) -> quot=0xFFFE8000 (-3.0).
REQ-034 SHALL cover: num=0x00008000, den=0 -> quot=0, div_zero=1, out_valid on the first edge after accept.
REQ-035 SHALL cover: num=0x40000000, den=0x00000001 -> quot=0x7FFFFFFF, sat=1; num=0xC0000000, den=0x00000001 -> quot=0x80000000, sat=1.
REQ-036 SHALL cover: out_ready held 0 for 10 cycles in DONE -> quot stable and in_ready=0; a new in_valid pulse applied then is ignored.
REQ-037 SHALL cover: reset asserted at iteration 20 of a division -> outputs at reset values immediately, no out_valid afterwards, and the next division (0x00008000/0x00028000) returns 0x00001999.
